// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - op encodings, FSM states and RMW helper for the I/O bus initiator
package io_bus_pkg;

    localparam logic [2:0] OP_WRITE  = 3'd0;
    localparam logic [2:0] OP_READ   = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_CLR    = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_RESP
    } io_state_e;

    // Value driven in the WR cycle; a plain WRITE passes its data straight through.
    function automatic logic [7:0] io_rmw_compute(input logic [2:0] op,
                                                  input logic [7:0] rdata,
                                                  input logic [7:0] mask);
        logic [7:0] res;
        case (op)
            OP_WRITE:  res = mask;
            OP_SET:    res = rdata | mask;
            OP_CLR:    res = rdata & ~mask;
            OP_TOGGLE: res = rdata ^ mask;
            default:   res = rdata;
        endcase
        return res;
    endfunction

    function automatic logic io_op_reserved(input logic [2:0] op);
        return op > OP_TOGGLE;
    endfunction

endpackage

// File: rtl/io_bus_initiator.sv
// rtl/io_bus_initiator.sv - request/response initiator for the 8-bit peripheral I/O bus with atomic RMW ops
module io_bus_initiator #(
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] io_address,
    output logic [7:0] io_dout,
    output logic       io_w_en,
    output logic       io_r_en,
    input  logic [7:0] io_din
);
    import io_bus_pkg::*;

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    io_state_e  state_q, state_d;
    logic [2:0] op_q;
    logic [2:0] cnt_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] rdata_q;
    logic [7:0] result_q;
    logic       err_q;
    logic       accept;
    logic [7:0] wr_value;

    assign accept   = req_valid && req_ready;
    assign wr_value = io_rmw_compute(op_q, rdata_q, data_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_op == OP_WRITE) begin
                        state_d = ST_WR;
                    end else if (io_op_reserved(req_op)) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = (op_q == OP_READ) ? ST_RESP : ST_WR;
                end
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes come only from the state register, so an async reset drops them at once.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        io_r_en   = 1'b0;
        io_w_en   = 1'b0;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_RD:   io_r_en   = 1'b1;
            ST_WR:   io_w_en   = 1'b1;
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= req_op;
                        addr_q <= req_addr;
                        data_q <= req_data;
                        err_q  <= io_op_reserved(req_op);
                        if (io_op_reserved(req_op)) begin
                            result_q <= '0;
                        end
                    end
                end
                ST_RD: cnt_q <= LAT_LOAD;
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        rdata_q <= io_din;
                        if (op_q == OP_READ) begin
                            result_q <= io_din;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_WR: result_q <= wr_value;
                default: ;
            endcase
        end
    end

    assign rsp_data   = result_q;
    assign rsp_err    = err_q;
    assign io_address = addr_q;
    assign io_dout    = wr_value;

endmodule

// File: tb/tb_io_bus_initiator.sv
// tb/tb_io_bus_initiator.sv - self-checking bench for io_bus_initiator against GPIO-style responders
module tb_io_bus_initiator;

    localparam logic [2:0] OW = 3'd0, OR = 3'd1, OS = 3'd2, OC = 3'd3, OT = 3'd4;
    localparam logic [7:0] PINS = 8'h3C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, resp_rst_n;

    logic       a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err, a_io_w_en, a_io_r_en;
    logic [2:0] a_req_op;
    logic [7:0] a_req_addr, a_req_data, a_rsp_data, a_io_address, a_io_dout, a_io_din;
    logic       b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_io_w_en, b_io_r_en;
    logic [2:0] b_req_op;
    logic [7:0] b_req_addr, b_req_data, b_rsp_data, b_io_address, b_io_dout, b_io_din;

    io_bus_initiator #(.READ_LATENCY(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
        .req_addr(a_req_addr), .req_data(a_req_data),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
        .io_address(a_io_address), .io_dout(a_io_dout), .io_w_en(a_io_w_en), .io_r_en(a_io_r_en),
        .io_din(a_io_din)
    );

    io_bus_initiator #(.READ_LATENCY(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
        .req_addr(b_req_addr), .req_data(b_req_data),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .io_address(b_io_address), .io_dout(b_io_dout), .io_w_en(b_io_w_en), .io_r_en(b_io_r_en),
        .io_din(b_io_din)
    );

    function automatic logic [7:0] gpio_rd(input logic [7:0] addr, input logic [7:0] dir,
                                           input logic [7:0] port);
        case (addr)
            8'h00:   return dir;
            8'h01:   return port;
            8'h02:   return PINS;
            default: return 8'h00;
        endcase
    endfunction

    // Responders drive read data only in the cycle it is due; otherwise 0xEE.
    logic [7:0] a_dir, a_port, a_pd;
    logic       a_pv;
    always_ff @(posedge clk or negedge resp_rst_n) begin
        if (!resp_rst_n) begin
            a_dir <= '0; a_port <= '0; a_pd <= '0; a_pv <= 1'b0;
        end else begin
            if (a_io_w_en && a_io_address == 8'h00) a_dir  <= a_io_dout;
            if (a_io_w_en && a_io_address == 8'h01) a_port <= a_io_dout;
            a_pv <= a_io_r_en;
            a_pd <= gpio_rd(a_io_address, a_dir, a_port);
        end
    end
    assign a_io_din = a_pv ? a_pd : 8'hEE;

    logic [7:0] b_port;
    logic [2:0] b_pv;
    logic [7:0] b_pd [3];
    always_ff @(posedge clk or negedge resp_rst_n) begin
        if (!resp_rst_n) begin
            b_port <= 8'h5A; b_pv <= '0;
            b_pd[0] <= '0; b_pd[1] <= '0; b_pd[2] <= '0;
        end else begin
            if (b_io_w_en && b_io_address == 8'h01) b_port <= b_io_dout;
            b_pv    <= {b_pv[1:0], b_io_r_en};
            b_pd[0] <= gpio_rd(b_io_address, 8'h00, b_port);
            b_pd[1] <= b_pd[0];
            b_pd[2] <= b_pd[1];
        end
    end
    assign b_io_din = b_pv[2] ? b_pd[2] : 8'hEE;

    int a_wcnt = 0, a_rcnt = 0, b_rcnt = 0, b_acc = 0;
    logic both_seen = 1'b0;
    always @(posedge clk) begin
        if (a_io_w_en) a_wcnt <= a_wcnt + 1;
        if (a_io_r_en) a_rcnt <= a_rcnt + 1;
        if (b_io_r_en) b_rcnt <= b_rcnt + 1;
        if (b_req_valid && b_req_ready) b_acc <= b_acc + 1;
        if ((a_io_w_en && a_io_r_en) || (b_io_w_en && b_io_r_en)) both_seen <= 1'b1;
    end

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
        int         exp_r;
        int         exp_w;
        logic [7:0] exp_port;
    } vec_t;

    vec_t vecs [11];

    task automatic run_vec(input vec_t v, input int idx);
        int    lat, r0, w0;
        string tag;
        tag = $sformatf("v%0d", idx);
        r0  = a_rcnt;
        w0  = a_wcnt;
        @(negedge clk);
        chk({tag, "_req_ready"}, 32'(a_req_ready), 32'd1);
        a_req_valid = 1'b1; a_req_op = v.op; a_req_addr = v.addr; a_req_data = v.data;
        @(posedge clk); #1;
        a_req_valid = 1'b0; a_req_op = 3'd7; a_req_addr = 8'hFF; a_req_data = 8'h55;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!a_rsp_valid && lat < 20);
        chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_rsp_data"}, 32'(a_rsp_data), 32'(v.exp_data));
        chk({tag, "_rsp_err"}, 32'(a_rsp_err), 32'(v.exp_err));
        @(posedge clk); #1;
        chk({tag, "_r_en_count"}, 32'(a_rcnt - r0), 32'(v.exp_r));
        chk({tag, "_w_en_count"}, 32'(a_wcnt - w0), 32'(v.exp_w));
        chk({tag, "_port"}, 32'(a_port), 32'(v.exp_port));
        chk({tag, "_rsp_valid_after"}, 32'(a_rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, r0, cyc, prev, nresp;

        vecs[0]  = '{OW,   8'h01, 8'hA5, 8'hA5, 1'b0, 2, 0, 1, 8'hA5};
        vecs[1]  = '{OR,   8'h01, 8'h00, 8'hA5, 1'b0, 3, 1, 0, 8'hA5};
        vecs[2]  = '{OW,   8'h01, 8'hF0, 8'hF0, 1'b0, 2, 0, 1, 8'hF0};
        vecs[3]  = '{OS,   8'h01, 8'h0F, 8'hFF, 1'b0, 4, 1, 1, 8'hFF};
        vecs[4]  = '{OC,   8'h01, 8'h30, 8'hCF, 1'b0, 4, 1, 1, 8'hCF};
        vecs[5]  = '{OT,   8'h01, 8'hFF, 8'h30, 1'b0, 4, 1, 1, 8'h30};
        vecs[6]  = '{OR,   8'h02, 8'h00, PINS,  1'b0, 3, 1, 0, 8'h30};
        vecs[7]  = '{OW,   8'h00, 8'h0F, 8'h0F, 1'b0, 2, 0, 1, 8'h30};
        vecs[8]  = '{OR,   8'h00, 8'h00, 8'h0F, 1'b0, 3, 1, 0, 8'h30};
        vecs[9]  = '{3'd5, 8'h01, 8'h77, 8'h00, 1'b1, 1, 0, 0, 8'h30};
        vecs[10] = '{OS,   8'h00, 8'h80, 8'h8F, 1'b0, 4, 1, 1, 8'h30};

        rst_n = 1'b0; resp_rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_op = '0; a_req_addr = '0; a_req_data = '0; a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_op = '0; b_req_addr = '0; b_req_data = '0; b_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(a_rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(a_rsp_err), 32'd0);
        chk("rst_io_address", 32'(a_io_address), 32'd0);
        chk("rst_io_dout", 32'(a_io_dout), 32'd0);
        chk("rst_strobes", 32'({a_io_w_en, a_io_r_en}), 32'd0);
        rst_n = 1'b1; resp_rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i);
        end

        // Reserved op with a stalled consumer: response must hold steady.
        w0 = a_wcnt; r0 = a_rcnt;
        a_rsp_ready = 1'b0;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_op = 3'd6; a_req_addr = 8'h01; a_req_data = 8'h3C;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_rsp_valid", i), 32'(a_rsp_valid), 32'd1);
            chk($sformatf("stall%0d_rsp_err", i), 32'(a_rsp_err), 32'd1);
            chk($sformatf("stall%0d_rsp_data", i), 32'(a_rsp_data), 32'd0);
            chk($sformatf("stall%0d_req_ready", i), 32'(a_req_ready), 32'd0);
        end
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("stall_release_req_ready", 32'(a_req_ready), 32'd1);
        chk("stall_no_strobes", 32'((a_wcnt - w0) + (a_rcnt - r0)), 32'd0);

        // Reset during the WAIT of a SET: the write must never be issued.
        w0 = a_wcnt;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_op = OS; a_req_addr = 8'h01; a_req_data = 8'h0F;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_rst_rd_strobe", 32'(a_io_r_en), 32'd1);
        @(negedge clk);
        chk("rmw_rst_wait_strobe", 32'(a_io_r_en), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rmw_rst_strobes_async", 32'({a_io_w_en, a_io_r_en}), 32'd0);
        chk("rmw_rst_req_ready", 32'(a_req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rmw_rst_no_write", 32'(a_wcnt - w0), 32'd0);
        chk("rmw_rst_port", 32'(a_port), 32'h30);
        chk("rmw_rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rmw_rst_req_ready_after", 32'(a_req_ready), 32'd1);

        // READ_LATENCY=3 instance, req_valid held high across four reads.
        r0 = b_rcnt;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_op = OR; b_req_addr = 8'h01;
        cyc = 0; prev = 0; nresp = 0;
        while (nresp < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (b_rsp_valid) begin
                chk($sformatf("lat3_rsp%0d_data", nresp), 32'(b_rsp_data), 32'h5A);
                if (nresp == 0) chk("lat3_first_latency", 32'(cyc), 32'd5);
                else            chk($sformatf("lat3_gap%0d", nresp), 32'(cyc - prev), 32'd6);
                prev = cyc;
                nresp++;
                if (nresp == 4) b_req_valid = 1'b0;
            end
        end
        chk("lat3_responses", 32'(nresp), 32'd4);
        repeat (4) @(negedge clk);
        chk("lat3_accepts", 32'(b_acc), 32'd4);
        chk("lat3_r_en_count", 32'(b_rcnt - r0), 32'd4);
        chk("lat3_idle_req_ready", 32'(b_req_ready), 32'd1);

        chk("no_dual_strobe", 32'(both_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
